// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder:
// FSM encoding and the active-low {g,f,e,d,c,b,a} glyph patterns.
package seg_scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble,
// with separate flags for an all-dark digit and an unrecognised glyph.
module seg7_to_hex
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       err
);

   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      err    = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit seven-segment display and reconstructs the
// shown value once every digit has been seen stable for SETTLE_CYCLES.
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  digit_in,
   output logic [15:0] value,
   output logic [3:0]  blank_mask,
   output logic        value_valid,
   output logic        frame_done,
   output logic        decode_err
);

   localparam int               CNT_W   = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [6:0] seg_sync [SYNC_STAGES];
   logic [3:0] dig_sync [SYNC_STAGES];
   logic [6:0] seg_p0;
   logic [3:0] dig_p0;

   // Input synchronizers; all-ones means no segment lit and no digit selected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            seg_sync[i] <= '1;
            dig_sync[i] <= '1;
         end
      end else begin
         seg_sync[0] <= seg_in;
         dig_sync[0] <= digit_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            seg_sync[i] <= seg_sync[i-1];
            dig_sync[i] <= dig_sync[i-1];
         end
      end
   end

   assign seg_p0 = seg_sync[SYNC_STAGES-1];
   assign dig_p0 = dig_sync[SYNC_STAGES-1];

   logic       sel_valid;
   logic [1:0] sel_idx;

   always_comb begin
      sel_valid = 1'b1;
      sel_idx   = 2'd0;
      case (~dig_p0)
         4'b0001: sel_idx = 2'd0;
         4'b0010: sel_idx = 2'd1;
         4'b0100: sel_idx = 2'd2;
         4'b1000: sel_idx = 2'd3;
         default: sel_valid = 1'b0;
      endcase
   end

   logic [6:0] prev_seg;
   logic [1:0] prev_idx;
   logic       changed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_seg <= '1;
         prev_idx <= 2'd0;
      end else begin
         prev_seg <= seg_p0;
         prev_idx <= sel_idx;
      end
   end

   assign changed = (seg_p0 != prev_seg) || (sel_idx != prev_idx);

   logic [3:0] dec_nibble;
   logic       dec_blank;
   logic       dec_err;

   seg7_to_hex u_dec (
      .seg    (seg_p0),
      .nibble (dec_nibble),
      .blank  (dec_blank),
      .err    (dec_err)
   );

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             settled;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // The capture fires on the edge that brings the counter to SETTLE_CYCLES.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      settled  = 1'b0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               state_nx = SETTLE;
               cnt_nx   = CNT_ONE;
            end
         end
         SETTLE: begin
            if (!sel_valid) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (changed) begin
               cnt_nx = CNT_ONE;
            end else begin
               if (cnt != CNT_MAX) cnt_nx = cnt + CNT_ONE;
               if (cnt == CNT_MAX - CNT_ONE) begin
                  settled  = 1'b1;
                  state_nx = HELD;
               end
            end
         end
         HELD: begin
            if (!sel_valid) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (changed) begin
               state_nx = SETTLE;
               cnt_nx   = CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   logic        capture;
   logic [3:0]  cap_mask;
   logic [3:0]  captured;
   logic [15:0] slot_value;
   logic [3:0]  slot_blank;
   logic        all_set;

   assign capture  = settled & ~dec_err;
   assign cap_mask = capture ? (4'b0001 << sel_idx) : 4'b0000;
   assign all_set  = &captured;

   // Frame assembly: a capture coinciding with the frame clear seeds the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         captured    <= 4'b0;
         slot_value  <= 16'h0;
         slot_blank  <= 4'b0;
         value       <= 16'h0;
         blank_mask  <= 4'b0;
         value_valid <= 1'b0;
         frame_done  <= 1'b0;
         decode_err  <= 1'b0;
      end else begin
         frame_done <= all_set;
         decode_err <= settled & dec_err;
         captured   <= (all_set ? 4'b0 : captured) | cap_mask;
         if (all_set) begin
            value       <= slot_value;
            blank_mask  <= slot_blank;
            value_valid <= 1'b1;
         end
         if (capture) begin
            slot_value[{sel_idx, 2'b00} +: 4] <= dec_nibble;
            slot_blank[sel_idx]               <= dec_blank;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built digit sequences and
// compares the reconstructed frame against hand-computed values.
module tb_seg_scan_decoder;
   import seg_scan_decoder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg_in;
   logic [3:0]  digit_in;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic        value_valid;
   logic        frame_done;
   logic        decode_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_frame  = 0;
   int n_err    = 0;

   localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg_scan_decoder #(.SYNC_STAGES(2), .SETTLE_CYCLES(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg_in      (seg_in),
      .digit_in    (digit_in),
      .value       (value),
      .blank_mask  (blank_mask),
      .value_valid (value_valid),
      .frame_done  (frame_done),
      .decode_err  (decode_err)
   );

   always @(negedge clk) begin
      if (frame_done) n_frame++;
      if (decode_err) n_err++;
   end

   task automatic show(input logic [6:0] s, input int k, input int n);
      seg_in   = s;
      digit_in = ~(4'b0001 << k);
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] v, input int n);
      for (int k = 3; k >= 0; k--) show(PAT[v[4*k +: 4]], k, n);
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      seg_in   = '1;
      digit_in = '1;
      repeat (3) @(negedge clk);
      n_checks++; if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value got=%h exp=0000", value); end
      n_checks++; if (blank_mask !== 4'h0) begin n_fail++; $display("FAIL reset_blank got=%b exp=0000", blank_mask); end
      n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", value_valid); end
      n_checks++; if (frame_done !== 1'b0 || decode_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", frame_done, decode_err); end
      n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_scan_latency;
      int lat = -1;
      int f0  = n_frame;
      show(PAT[1], 3, 100);
      show(PAT[2], 2, 100);
      show(PAT[3], 1, 100);
      n_checks++; if (value_valid !== 1'b0 || n_frame != f0) begin
         n_fail++; $display("FAIL partial_frame valid=%b frames=%0d exp valid=0 frames=%0d", value_valid, n_frame, f0); end
      seg_in   = PAT[4];
      digit_in = 4'b1110;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (frame_done) begin lat = c; break; end
      end
      n_checks++; if (lat != 19) begin n_fail++; $display("FAIL latency got=%0d exp=19", lat); end
      @(posedge clk); #1;
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_pulse_width got=%b exp=0", frame_done); end
      @(negedge clk);
      repeat (80) @(negedge clk);
      n_checks++; if (n_frame != f0 + 1) begin n_fail++; $display("FAIL scan_frames got=%0d exp=%0d", n_frame, f0 + 1); end
      n_checks++; if (value !== 16'h1234) begin n_fail++; $display("FAIL scan_value got=%h exp=1234", value); end
      n_checks++; if (value_valid !== 1'b1) begin n_fail++; $display("FAIL scan_valid got=%b exp=1", value_valid); end
      n_checks++; if (blank_mask !== 4'b0000) begin n_fail++; $display("FAIL scan_blank got=%b exp=0000", blank_mask); end
   endtask

   task automatic test_back_to_back;
      int f0 = n_frame;
      scan(16'h1234, 100);
      scan(16'h1234, 100);
      n_checks++; if (n_frame != f0 + 2) begin n_fail++; $display("FAIL b2b_frames got=%0d exp=%0d", n_frame, f0 + 2); end
   endtask

   task automatic test_glitch;
      int f0 = n_frame;
      show(PAT[1], 3, 100);
      show(PAT[2], 2, 100);
      show(PAT[3], 1, 100);
      show(PAT[4], 0, 10);
      show(PAT[8], 0, 5);
      show(PAT[4], 0, 100);
      n_checks++; if (n_frame != f0 + 1) begin n_fail++; $display("FAIL glitch_frames got=%0d exp=%0d", n_frame, f0 + 1); end
      n_checks++; if (value !== 16'h1234) begin n_fail++; $display("FAIL glitch_value got=%h exp=1234", value); end
   endtask

   task automatic test_blank;
      int f0 = n_frame;
      show(PAT[0], 3, 100);
      show(7'h7F,  2, 100);
      show(PAT[0], 1, 100);
      show(PAT[0], 0, 100);
      n_checks++; if (n_frame != f0 + 1) begin n_fail++; $display("FAIL blank_frames got=%0d exp=%0d", n_frame, f0 + 1); end
      n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL blank_value got=%h exp=0000", value); end
      n_checks++; if (blank_mask !== 4'b0100) begin n_fail++; $display("FAIL blank_mask got=%b exp=0100", blank_mask); end
      n_checks++; if (dut.state !== HELD || dut.cnt !== 5'd16) begin
         n_fail++; $display("FAIL held_saturate state=%0d cnt=%0d exp state=%0d cnt=16", dut.state, dut.cnt, HELD); end
   endtask

   task automatic test_all_digits;
      scan(16'h9EF0, 100);
      n_checks++; if (value !== 16'h9EF0) begin n_fail++; $display("FAIL digits_value got=%h exp=9ef0", value); end
      n_checks++; if (blank_mask !== 4'b0000) begin n_fail++; $display("FAIL digits_blank got=%b exp=0000", blank_mask); end
   endtask

   task automatic test_decode_err;
      int f0 = n_frame;
      int e0 = n_err;
      show(PAT[5], 3, 100);
      show(PAT[6], 2, 100);
      show(7'h55,  1, 100);
      show(PAT[8], 0, 100);
      n_checks++; if (n_err != e0 + 1) begin n_fail++; $display("FAIL err_pulses got=%0d exp=%0d", n_err, e0 + 1); end
      n_checks++; if (n_frame != f0) begin n_fail++; $display("FAIL err_no_frame got=%0d exp=%0d", n_frame, f0); end
      show(PAT[7], 1, 100);
      n_checks++; if (n_frame != f0 + 1) begin n_fail++; $display("FAIL err_recover_frames got=%0d exp=%0d", n_frame, f0 + 1); end
      n_checks++; if (value !== 16'h5678) begin n_fail++; $display("FAIL err_recover_value got=%h exp=5678", value); end
   endtask

   task automatic test_invalid_select;
      int f0 = n_frame;
      int e0 = n_err;
      seg_in   = PAT[3];
      digit_in = 4'b1100;
      repeat (200) @(negedge clk);
      n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL multi_sel_state got=%0d exp=%0d", dut.state, IDLE); end
      n_checks++; if (n_frame != f0 || n_err != e0 || dut.captured !== 4'b0000) begin
         n_fail++; $display("FAIL multi_sel_effects frames=%0d errs=%0d flags=%b exp %0d %0d 0000", n_frame, n_err, dut.captured, f0, e0); end
      digit_in = 4'b1111;
      repeat (50) @(negedge clk);
      n_checks++; if (dut.state !== IDLE || dut.captured !== 4'b0000) begin
         n_fail++; $display("FAIL no_sel state=%0d flags=%b exp=%0d 0000", dut.state, dut.captured, IDLE); end
   endtask

   task automatic test_reset_mid_frame;
      int f0;
      show(PAT[1], 0, 100);
      show(PAT[2], 1, 100);
      show(PAT[3], 2, 100);
      reset    = 1'b1;
      seg_in   = '1;
      digit_in = '1;
      repeat (2) @(negedge clk);
      n_checks++; if (value !== 16'h0 || value_valid !== 1'b0 || blank_mask !== 4'h0) begin
         n_fail++; $display("FAIL midreset_outputs value=%h valid=%b blank=%b exp 0000 0 0000", value, value_valid, blank_mask); end
      reset = 1'b0;
      @(negedge clk);
      f0 = n_frame;
      show(PAT[10], 3, 100);
      n_checks++; if (n_frame != f0) begin n_fail++; $display("FAIL midreset_discard got=%0d exp=%0d", n_frame, f0); end
      show(PAT[11], 2, 100);
      show(PAT[12], 1, 100);
      n_checks++; if (n_frame != f0 || value_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_early frames=%0d valid=%b exp=%0d 0", n_frame, value_valid, f0); end
      show(PAT[13], 0, 100);
      n_checks++; if (n_frame != f0 + 1) begin n_fail++; $display("FAIL abcd_frames got=%0d exp=%0d", n_frame, f0 + 1); end
      n_checks++; if (value !== 16'hABCD || value_valid !== 1'b1) begin
         n_fail++; $display("FAIL abcd_value got=%h valid=%b exp=abcd 1", value, value_valid); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_scan_latency();
      test_back_to_back();
      test_glitch();
      test_blank();
      test_all_digits();
      test_decode_err();
      test_invalid_select();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, stable cycles required before capture (2..1023).
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port seg_in  input  7  active-low segments {g,f,e,d,c,b,a}, seg_in[0]=a.
REQ-006 SHALL have port digit_in  input  4  active-low digit enables, digit_in[0]=rightmost digit.
REQ-007 SHALL have port value  output  16  last complete frame, digit k in value[4k+3:4k].
REQ-008 SHALL have port blank_mask  output  4  bit k set when digit k was blank in last frame.
REQ-009 SHALL have port value_valid  output  1  sticky, set by first complete frame.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on each completed frame.
REQ-011 SHALL have port decode_err  output  1  one-cycle pulse on an unrecognised settled pattern.

Function
REQ-012 SHALL pass seg_in and digit_in through SYNC_STAGES flops; all decoding uses synchronized values only.
REQ-013 SHALL treat a select as valid only when exactly one digit_in bit is low; zero or multiple low bits are invalid.
REQ-014 SHALL implement states IDLE, SETTLE, HELD.
REQ-015 IDLE: invalid select; on valid select -> SETTLE, settle counter loaded to 1.
REQ-016 SETTLE: counter increments while select index and seg unchanged; any change of either reloads counter to 1 (invalid select -> IDLE).
REQ-017 SETTLE: on counter reaching SETTLE_CYCLES, decode and capture into slot k, then -> HELD in the same cycle.
REQ-018 HELD: no further capture; select index or seg change -> SETTLE (counter 1), invalid select -> IDLE.
REQ-019 Decode (active-low hex): 40->0,79->1,24->2,30->3,19->4,12->5,02->6,78->7,00->8,10->9,08->A,03->b,46->C,21->d,06->E,0E->F.
REQ-020 Pattern 7F SHALL capture nibble 0 with slot blank bit set; any other unlisted pattern SHALL pulse decode_err the cycle after settle and SHALL NOT mark slot k captured.
REQ-021 Each slot SHALL hold a captured flag; recapture of an already-captured slot overwrites its nibble/blank bit.
REQ-022 When all four captured flags are set, next cycle: value and blank_mask update from slots, frame_done pulses, value_valid sets, all flags clear.
REQ-023 A capture arriving in the frame_done cycle SHALL set its flag after the clear (belongs to next frame).
REQ-024 Latency: last qualifying input edge to frame_done = SYNC_STAGES + SETTLE_CYCLES + 1 cycles.
REQ-025 Settle counter SHALL saturate, never wrap.

Reset
REQ-026 Asserting reset at any time SHALL force IDLE, counter 0, all flags/slots 0, value 0, blank_mask 0, value_valid 0, frame_done 0, decode_err 0, synchronizer flops to all-ones (inactive).
REQ-027 A partial frame in progress at reset SHALL be discarded.

Structure
REQ-028 Shared package SHALL hold state encoding, 7-bit segment pattern constants, blank constant 7F.
REQ-029 One sub-module seg7_to_hex (combinational: pattern -> nibble, blank, err) is natural; the rest is one module.

Verification
REQ-030 Scan 1234 (digits 3..0 = 1,2,3,4), 100 cycles per digit -> frame_done once per scan, value=16'h1234, value_valid=1, blank_mask=0.
REQ-031 Digit 2 holds 7F, others 0 -> value=16'h0000, blank_mask=4'b0100.
REQ-032 Digit 1 shows 7'h55 -> one decode_err pulse, no frame_done until valid digit 1 is scanned.
REQ-033 Change digit 0 glitch for 5 cycles (< SETTLE_CYCLES), then restore -> no capture of glitch value, value unchanged.
REQ-034 digit_in=4'b1100 for 200 cycles -> state IDLE, no capture, no decode_err.
REQ-035 Reset after digits 0..2 captured, then scan ABCD -> first frame_done yields value=16'hABCD only after all four digits rescanned.
